// File: rtl/ctrl_pipe.sv
// ctrl_pipe: control-side pipeline registers (ID/EX, EX/MEM, MEM/WB) for a
// 5-stage pipeline, with load-use hazard detection and stall/flush generation.
//
// Ports:
//   clk, reset        rising-edge clock, asynchronous active-high reset
//   id_ctrl[9:0]      decoded control bits from ID:
//                     {RegDest, Branch, MemRead, MemToReg, ALUOp1, ALUOp2,
//                      MemWrite, ALUSrc, RegWrite, Jump}
//   id_rs/rt/rd       register fields of the instruction in ID
//   ex_branch_taken   branch in EX resolved taken
//   stall             hold PC and IF/ID (combinational)
//   flush_ifid        squash IF/ID (combinational)
//   ex_*              ID/EX stage controls and register specifiers
//   mem_*             EX/MEM stage controls and destination
//   wb_*              MEM/WB stage controls and destination
//   stall_count       saturating count of stall cycles
module ctrl_pipe #(
  parameter int unsigned REG_W = 5,
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [9:0]       id_ctrl,
  input  logic [REG_W-1:0] id_rs,
  input  logic [REG_W-1:0] id_rt,
  input  logic [REG_W-1:0] id_rd,
  input  logic             ex_branch_taken,
  output logic             stall,
  output logic             flush_ifid,
  output logic [1:0]       ex_ALUOp,
  output logic             ex_ALUSrc,
  output logic             ex_Branch,
  output logic             ex_MemRead,
  output logic [REG_W-1:0] ex_rs,
  output logic [REG_W-1:0] ex_rt,
  output logic [REG_W-1:0] ex_dest,
  output logic             mem_MemRead,
  output logic             mem_MemWrite,
  output logic             mem_MemToReg,
  output logic             mem_RegWrite,
  output logic [REG_W-1:0] mem_dest,
  output logic             wb_MemToReg,
  output logic             wb_RegWrite,
  output logic [REG_W-1:0] wb_dest,
  output logic [CNT_W-1:0] stall_count
);

  // ID/EX state
  logic [1:0]       ex_aluop_q, ex_aluop_d;
  logic             ex_alusrc_q, ex_alusrc_d;
  logic             ex_branch_q, ex_branch_d;
  logic             ex_memread_q, ex_memread_d;
  logic             ex_memwrite_q, ex_memwrite_d;
  logic             ex_memtoreg_q, ex_memtoreg_d;
  logic             ex_regwrite_q, ex_regwrite_d;
  logic [REG_W-1:0] ex_rs_q, ex_rs_d;
  logic [REG_W-1:0] ex_rt_q, ex_rt_d;
  logic [REG_W-1:0] ex_dest_q, ex_dest_d;

  // EX/MEM and MEM/WB state
  logic             mem_memread_q, mem_memwrite_q, mem_memtoreg_q, mem_regwrite_q;
  logic [REG_W-1:0] mem_dest_q;
  logic             wb_memtoreg_q, wb_regwrite_q;
  logic [REG_W-1:0] wb_dest_q;

  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

  logic             hazard_c;
  logic             bubble_c;
  logic [REG_W-1:0] id_dest_c;

  assign id_dest_c = id_ctrl[9] ? id_rd : id_rt;

  // Load in EX whose target feeds the instruction in ID; r0 never creates a dependency.
  assign hazard_c = ex_memread_q & (ex_rt_q != '0) &
                    ((ex_rt_q == id_rs) | (ex_rt_q == id_rt));

  // Hazard priority and next ID/EX value
  always_comb begin
    stall      = 1'b0;
    flush_ifid = 1'b0;
    bubble_c   = 1'b0;
    if (reset) begin
      bubble_c = 1'b1;
    end else if (ex_branch_taken) begin
      flush_ifid = 1'b1;
      bubble_c   = 1'b1;
    end else if (hazard_c) begin
      stall    = 1'b1;
      bubble_c = 1'b1;
    end else if (id_ctrl[0]) begin
      flush_ifid = 1'b1;
    end

    ex_aluop_d    = id_ctrl[5:4];
    ex_alusrc_d   = id_ctrl[2];
    ex_branch_d   = id_ctrl[8];
    ex_memread_d  = id_ctrl[7];
    ex_memwrite_d = id_ctrl[3];
    ex_memtoreg_d = id_ctrl[6];
    // Writes to r0 are dropped here so later stages never see them.
    ex_regwrite_d = id_ctrl[1] & (id_dest_c != '0);
    ex_rs_d       = id_rs;
    ex_rt_d       = id_rt;
    ex_dest_d     = id_dest_c;
    if (bubble_c) begin
      ex_aluop_d    = 2'b00;
      ex_alusrc_d   = 1'b0;
      ex_branch_d   = 1'b0;
      ex_memread_d  = 1'b0;
      ex_memwrite_d = 1'b0;
      ex_memtoreg_d = 1'b0;
      ex_regwrite_d = 1'b0;
      ex_rs_d       = '0;
      ex_rt_d       = '0;
      ex_dest_d     = '0;
    end
  end

  // Saturating stall counter next value
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (stall && (stall_cnt_q != '1)) begin
      stall_cnt_d = stall_cnt_q + CNT_W'(1);
    end
  end

  // Pipeline registers; EX/MEM and MEM/WB advance unconditionally
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ex_aluop_q     <= 2'b00;
      ex_alusrc_q    <= 1'b0;
      ex_branch_q    <= 1'b0;
      ex_memread_q   <= 1'b0;
      ex_memwrite_q  <= 1'b0;
      ex_memtoreg_q  <= 1'b0;
      ex_regwrite_q  <= 1'b0;
      ex_rs_q        <= '0;
      ex_rt_q        <= '0;
      ex_dest_q      <= '0;
      mem_memread_q  <= 1'b0;
      mem_memwrite_q <= 1'b0;
      mem_memtoreg_q <= 1'b0;
      mem_regwrite_q <= 1'b0;
      mem_dest_q     <= '0;
      wb_memtoreg_q  <= 1'b0;
      wb_regwrite_q  <= 1'b0;
      wb_dest_q      <= '0;
      stall_cnt_q    <= '0;
    end else begin
      ex_aluop_q     <= ex_aluop_d;
      ex_alusrc_q    <= ex_alusrc_d;
      ex_branch_q    <= ex_branch_d;
      ex_memread_q   <= ex_memread_d;
      ex_memwrite_q  <= ex_memwrite_d;
      ex_memtoreg_q  <= ex_memtoreg_d;
      ex_regwrite_q  <= ex_regwrite_d;
      ex_rs_q        <= ex_rs_d;
      ex_rt_q        <= ex_rt_d;
      ex_dest_q      <= ex_dest_d;
      mem_memread_q  <= ex_memread_q;
      mem_memwrite_q <= ex_memwrite_q;
      mem_memtoreg_q <= ex_memtoreg_q;
      mem_regwrite_q <= ex_regwrite_q;
      mem_dest_q     <= ex_dest_q;
      wb_memtoreg_q  <= mem_memtoreg_q;
      wb_regwrite_q  <= mem_regwrite_q;
      wb_dest_q      <= mem_dest_q;
      stall_cnt_q    <= stall_cnt_d;
    end
  end

  assign ex_ALUOp     = ex_aluop_q;
  assign ex_ALUSrc    = ex_alusrc_q;
  assign ex_Branch    = ex_branch_q;
  assign ex_MemRead   = ex_memread_q;
  assign ex_rs        = ex_rs_q;
  assign ex_rt        = ex_rt_q;
  assign ex_dest      = ex_dest_q;
  assign mem_MemRead  = mem_memread_q;
  assign mem_MemWrite = mem_memwrite_q;
  assign mem_MemToReg = mem_memtoreg_q;
  assign mem_RegWrite = mem_regwrite_q;
  assign mem_dest     = mem_dest_q;
  assign wb_MemToReg  = wb_memtoreg_q;
  assign wb_RegWrite  = wb_regwrite_q;
  assign wb_dest      = wb_dest_q;
  assign stall_count  = stall_cnt_q;

endmodule
